// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI-mode initialisation controller:
// timing defaults, state encodings and fixed command frames.
package sd_pkg;

  localparam int unsigned DEF_CLK_DIV       = 2;
  localparam int unsigned DEF_TIMEOUT_BYTES = 8;
  localparam int unsigned DEF_DUMMY_CLKS    = 80;

  // Slot counter covers max(DUMMY_CLKS, TIMEOUT_BYTES*8) up to 256.
  localparam int CNT_W = 8;
  localparam int DIV_W = 8;

  localparam logic [47:0] FRAME_CMD0   = 48'h40_00000000_95;
  localparam logic [47:0] FRAME_CMD8   = 48'h48_000001AA_87;
  localparam logic [47:0] FRAME_CMD55  = 48'h77_00000000_FF;
  localparam logic [47:0] FRAME_ACMD41 = 48'h69_40000000_FF;

  localparam logic [7:0] R1_READY      = 8'h00;
  localparam logic [7:0] R1_IDLE       = 8'h01;
  localparam logic [7:0] CHECK_PATTERN = 8'hAA;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DUMMY    = 4'd1,
    CMD0     = 4'd2,
    R_CMD0   = 4'd3,
    CMD8     = 4'd4,
    R_CMD8   = 4'd5,
    CMD55    = 4'd6,
    R_CMD55  = 4'd7,
    ACMD41   = 4'd8,
    R_ACMD41 = 4'd9,
    DONE     = 4'd10
  } sd_state_t;

  typedef enum logic [2:0] {
    PH_SHIFT = 3'd0,
    PH_WAIT  = 3'd1,
    PH_R1    = 3'd2,
    PH_TAIL  = 3'd3,
    PH_GAP   = 3'd4
  } sd_phase_t;

  function automatic logic [47:0] cmd_frame(input sd_state_t s);
    case (s)
      CMD0:    return FRAME_CMD0;
      CMD8:    return FRAME_CMD8;
      CMD55:   return FRAME_CMD55;
      ACMD41:  return FRAME_ACMD41;
      default: return '1;
    endcase
  endfunction

  function automatic sd_state_t rsp_of(input sd_state_t s);
    case (s)
      CMD0:    return R_CMD0;
      CMD8:    return R_CMD8;
      CMD55:   return R_CMD55;
      ACMD41:  return R_ACMD41;
      default: return s;
    endcase
  endfunction

  function automatic sd_state_t cmd_of(input sd_state_t s);
    case (s)
      R_CMD0:   return CMD0;
      R_CMD8:   return CMD8;
      R_CMD55:  return CMD55;
      R_ACMD41: return ACMD41;
      default:  return s;
    endcase
  endfunction

endpackage

// File: rtl/sd_initial.sv
// SD SPI-mode initialisation engine: SPI clock divider, command shifter,
// response capture and the init sequencing FSM.
//
// state    | meaning
// IDLE     | one cycle after reset, then start dummy clocks
// DUMMY    | DUMMY_CLKS SPI clocks with MOSI high
// CMDx     | shift out the 48-bit frame of command x
// R_CMDx   | wait for R1 start bit, read R1 (+32 bits for CMD8), 8 gap clocks
// DONE     | card ready, SPI clock stopped
module sd_initial
  import sd_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned TIMEOUT_BYTES = DEF_TIMEOUT_BYTES,
  parameter int unsigned DUMMY_CLKS    = DEF_DUMMY_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  output logic sd_ck,
  output logic sd_mosi,
  input  logic sd_miso,
  output logic init_done
);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CLKS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_BYTES * 8 - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(47);
  localparam logic [CNT_W-1:0] R1_LAST    = CNT_W'(6);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(31);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(7);

  sd_state_t        state, state_nxt, resp_next;
  sd_phase_t        phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             sck, miso_smp;
  logic [47:0]      tx_sr;
  logic [7:0]       r1, tail;
  logic             frame_ld, active, tick, sck_rise, slot_end;

  // One SPI bit slot = CLK_DIV clocks low then CLK_DIV clocks high.
  assign active   = (state != IDLE) && (state != DONE);
  assign tick     = active && (div_cnt == '0);
  assign sck_rise = tick && !sck;
  assign slot_end = tick && sck;

  assign sd_ck     = sck;
  assign sd_mosi   = (phase == PH_SHIFT) ? tx_sr[47] : 1'b1;
  assign init_done = (state == DONE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!active) begin
      div_cnt <= DIV_RELOAD;
      sck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= DIV_RELOAD;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      phase <= PH_GAP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_sr    <= '0;
      r1       <= '0;
      tail     <= '0;
      miso_smp <= 1'b0;
    end else begin
      if (sck_rise) miso_smp <= sd_miso;
      if (frame_ld) tx_sr <= cmd_frame(state_nxt);
      else if (slot_end && phase == PH_SHIFT) tx_sr <= {tx_sr[46:0], 1'b1};
      if (slot_end && (phase == PH_WAIT || phase == PH_R1)) r1 <= {r1[6:0], miso_smp};
      if (slot_end && phase == PH_TAIL) tail <= {tail[6:0], miso_smp};
    end
  end

  always_comb begin
    resp_next = state;
    case (state)
      R_CMD0:   resp_next = (r1 == R1_IDLE) ? CMD8 : CMD0;
      R_CMD8:   resp_next = (r1 == R1_IDLE && tail == CHECK_PATTERN) ? CMD55 : CMD0;
      R_CMD55:  resp_next = ACMD41;
      R_ACMD41: resp_next = (r1 == R1_READY) ? DONE :
                            (r1 == R1_IDLE)  ? CMD55 : CMD0;
      default:  resp_next = state;
    endcase
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    frame_ld  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = DUMMY;
        phase_nxt = PH_GAP;
        cnt_nxt   = DUMMY_LAST;
      end
      DUMMY: begin
        if (slot_end) begin
          if (cnt == '0) begin
            state_nxt = CMD0;
            phase_nxt = PH_SHIFT;
            cnt_nxt   = FRAME_LAST;
            frame_ld  = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      CMD0, CMD8, CMD55, ACMD41: begin
        if (slot_end) begin
          if (cnt == '0) begin
            state_nxt = rsp_of(state);
            phase_nxt = PH_WAIT;
            cnt_nxt   = WAIT_LAST;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      R_CMD0, R_CMD8, R_CMD55, R_ACMD41: begin
        if (slot_end) begin
          case (phase)
            PH_WAIT: begin
              if (!miso_smp) begin
                phase_nxt = PH_R1;
                cnt_nxt   = R1_LAST;
              end else if (cnt == '0) begin
                // No start bit seen: resend the same command straight away.
                state_nxt = cmd_of(state);
                phase_nxt = PH_SHIFT;
                cnt_nxt   = FRAME_LAST;
                frame_ld  = 1'b1;
              end else begin
                cnt_nxt = cnt - CNT_W'(1);
              end
            end
            PH_R1: begin
              if (cnt == '0) begin
                phase_nxt = (state == R_CMD8) ? PH_TAIL : PH_GAP;
                cnt_nxt   = (state == R_CMD8) ? TAIL_LAST : GAP_LAST;
              end else begin
                cnt_nxt = cnt - CNT_W'(1);
              end
            end
            PH_TAIL: begin
              if (cnt == '0) begin
                phase_nxt = PH_GAP;
                cnt_nxt   = GAP_LAST;
              end else begin
                cnt_nxt = cnt - CNT_W'(1);
              end
            end
            PH_GAP: begin
              if (cnt == '0) begin
                state_nxt = resp_next;
                if (resp_next != DONE) begin
                  phase_nxt = PH_SHIFT;
                  cnt_nxt   = FRAME_LAST;
                  frame_ld  = 1'b1;
                end
              end else begin
                cnt_nxt = cnt - CNT_W'(1);
              end
            end
            default: phase_nxt = PH_GAP;
          endcase
        end
      end
      DONE: begin
        state_nxt = DONE;
        phase_nxt = PH_GAP;
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = PH_GAP;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sd_ctrl_top.sv
// SD card SPI-mode initialisation controller top: wraps the sequencing engine.
module sd_ctrl_top
  import sd_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned TIMEOUT_BYTES = DEF_TIMEOUT_BYTES,
  parameter int unsigned DUMMY_CLKS    = DEF_DUMMY_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  output logic SD_CK,
  output logic SD_MOSI,
  input  logic SD_MISO,
  output logic init_done
);

  sd_initial #(
    .CLK_DIV       (CLK_DIV),
    .TIMEOUT_BYTES (TIMEOUT_BYTES),
    .DUMMY_CLKS    (DUMMY_CLKS)
  ) sd_initial (
    .clk       (clk),
    .rst_n     (rst_n),
    .sd_ck     (SD_CK),
    .sd_mosi   (SD_MOSI),
    .sd_miso   (SD_MISO),
    .init_done (init_done)
  );

endmodule

// File: tb/tb_sd_ctrl_top.sv
// Directed bench for sd_ctrl_top: acts as the SD card bit by bit and checks
// the command sequence, timing gaps, retries, completion and reset abort.
module tb_sd_ctrl_top;

  localparam logic [47:0] EXP_CMD0   = 48'h400000000095;
  localparam logic [47:0] EXP_CMD8   = 48'h48000001AA87;
  localparam logic [47:0] EXP_CMD55  = 48'h7700000000FF;
  localparam logic [47:0] EXP_ACMD41 = 48'h6940000000FF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic SD_CK, SD_MOSI, init_done;
  logic SD_MISO = 1'b1;

  int tests = 0;
  int fails = 0;
  int stalls = 0;

  sd_ctrl_top DUT (
    .clk       (clk),
    .rst_n     (rst_n),
    .SD_CK     (SD_CK),
    .SD_MOSI   (SD_MOSI),
    .SD_MISO   (SD_MISO),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // One SPI bit: present MISO, return MOSI seen at SD_CK high, end after the fall.
  task automatic slot(input logic mi, output logic mo);
    int n;
    SD_MISO = mi;
    n = 0;
    while (SD_CK !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) stalls++;
    mo = SD_MOSI;
    n = 0;
    while (SD_CK !== 1'b0 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) stalls++;
  endtask

  task automatic respond(input int delay, input int nbits, input logic [39:0] data,
                         output bit all1);
    logic mo;
    all1 = 1'b1;
    for (int i = 0; i < delay; i++) begin
      slot(1'b1, mo);
      all1 = all1 & (mo === 1'b1);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      slot(data[i], mo);
      all1 = all1 & (mo === 1'b1);
    end
    SD_MISO = 1'b1;
  endtask

  // Count MOSI-high slots until a frame starts (all frames begin with 0), then read nbits.
  task automatic next_frame(input int nbits, output int idle, output logic [47:0] f);
    logic mo;
    idle = 0;
    slot(1'b1, mo);
    while (mo === 1'b1 && idle < 300) begin
      idle++;
      slot(1'b1, mo);
    end
    f = {47'b0, mo};
    for (int i = 1; i < nbits; i++) begin
      slot(1'b1, mo);
      f = {f[46:0], mo};
    end
  endtask

  task automatic test_reset;
    bit ck_seen;
    rst_n = 1'b1;
    ck_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (SD_CK !== 1'b0) ck_seen = 1'b1;
    end
    tests++; if (SD_CK !== 1'b0) begin fails++; $display("FAIL reset_sck: got %b want 0", SD_CK); end
    tests++; if (ck_seen) begin fails++; $display("FAIL reset_sck_idle: got toggling want low"); end
    tests++; if (SD_MOSI !== 1'b1) begin fails++; $display("FAIL reset_mosi: got %b want 1", SD_MOSI); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", init_done); end
    tests++; if (DUT.sd_initial.state !== 4'd0) begin
      fails++; $display("FAIL reset_state: got %0d want 0", DUT.sd_initial.state); end
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (DUT.sd_initial.state !== 4'd1) begin
      fails++; $display("FAIL idle_to_dummy: got %0d want 1", DUT.sd_initial.state); end
  endtask

  task automatic test_dummy;
    int idle; logic [47:0] f;
    next_frame(48, idle, f);
    tests++; if (idle != 80) begin fails++; $display("FAIL dummy_clks: got %0d want 80", idle); end
    tests++; if (f !== EXP_CMD0) begin fails++; $display("FAIL dummy_cmd0: got %h want %h", f, EXP_CMD0); end
  endtask

  task automatic test_cmd0_timeout;
    int idle; logic [47:0] f;
    for (int k = 0; k < 2; k++) begin
      next_frame(48, idle, f);
      tests++; if (idle != 64) begin fails++; $display("FAIL timeout_gap%0d: got %0d want 64", k, idle); end
      tests++; if (f !== EXP_CMD0) begin fails++; $display("FAIL timeout_cmd0_%0d: got %h want %h", k, f, EXP_CMD0); end
    end
  endtask

  task automatic test_cmd0_bad;
    int idle; logic [47:0] f; bit all1;
    respond(2, 8, 40'h05, all1);
    tests++; if (!all1) begin fails++; $display("FAIL rsp_mosi_high: got low want high"); end
    next_frame(48, idle, f);
    tests++; if (idle != 8) begin fails++; $display("FAIL cmd0_bad_gap: got %0d want 8", idle); end
    tests++; if (f !== EXP_CMD0) begin fails++; $display("FAIL cmd0_bad_resend: got %h want %h", f, EXP_CMD0); end
  endtask

  task automatic test_cmd0_ok;
    int idle; logic [47:0] f; bit all1;
    respond(1, 8, 40'h01, all1);
    next_frame(48, idle, f);
    tests++; if (idle != 8) begin fails++; $display("FAIL cmd0_ok_gap: got %0d want 8", idle); end
    tests++; if (f !== EXP_CMD8) begin fails++; $display("FAIL cmd8_frame: got %h want %h", f, EXP_CMD8); end
  endtask

  task automatic test_cmd8;
    int idle; logic [47:0] f; bit all1;
    respond(0, 40, 40'h01_00000055, all1);
    next_frame(48, idle, f);
    tests++; if (idle != 8) begin fails++; $display("FAIL cmd8_bad_gap: got %0d want 8", idle); end
    tests++; if (f !== EXP_CMD0) begin fails++; $display("FAIL cmd8_bad_cmd0: got %h want %h", f, EXP_CMD0); end
    respond(3, 8, 40'h01, all1);
    next_frame(48, idle, f);
    tests++; if (f !== EXP_CMD8) begin fails++; $display("FAIL cmd8_again: got %h want %h", f, EXP_CMD8); end
    respond(1, 40, 40'h01_000001AA, all1);
    tests++; if (!all1) begin fails++; $display("FAIL r7_mosi_high: got low want high"); end
    next_frame(48, idle, f);
    tests++; if (idle != 8) begin fails++; $display("FAIL cmd8_ok_gap: got %0d want 8", idle); end
    tests++; if (f !== EXP_CMD55) begin fails++; $display("FAIL cmd55_frame: got %h want %h", f, EXP_CMD55); end
  endtask

  task automatic test_acmd41_loop;
    int idle, n55, n41, k; logic [47:0] f; bit all1, ck_seen, mosi_low;
    n55 = 1; n41 = 0;
    for (int i = 0; i < 3; i++) begin
      respond(2, 8, 40'h01, all1);
      next_frame(48, idle, f);
      tests++; if (f !== EXP_ACMD41) begin fails++; $display("FAIL acmd41_frame%0d: got %h want %h", i, f, EXP_ACMD41); end
      if (f === EXP_ACMD41) n41++;
      if (i < 2) begin
        respond(1, 8, 40'h01, all1);
        next_frame(48, idle, f);
        tests++; if (f !== EXP_CMD55) begin fails++; $display("FAIL cmd55_again%0d: got %h want %h", i, f, EXP_CMD55); end
        if (f === EXP_CMD55) n55++;
      end
    end
    tests++; if (n55 != 3 || n41 != 3) begin
      fails++; $display("FAIL pair_count: got %0d/%0d want 3/3", n55, n41); end
    respond(1, 8, 40'h00, all1);
    k = 0;
    while (init_done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_done: got %b want 1", init_done); end
    tests++; if (DUT.sd_initial.state !== 4'd10) begin
      fails++; $display("FAIL done_state: got %0d want 10", DUT.sd_initial.state); end
    ck_seen = 1'b0; mosi_low = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (SD_CK !== 1'b0) ck_seen = 1'b1;
      if (SD_MOSI !== 1'b1) mosi_low = 1'b1;
    end
    tests++; if (ck_seen) begin fails++; $display("FAIL done_sck: got toggling want stopped"); end
    tests++; if (mosi_low) begin fails++; $display("FAIL done_mosi: got low want high"); end
  endtask

  task automatic test_reset_mid_acmd41;
    int idle, k; logic [47:0] f; bit all1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    next_frame(48, idle, f);
    respond(1, 8, 40'h01, all1);
    next_frame(48, idle, f);
    respond(1, 40, 40'h01_000001AA, all1);
    next_frame(48, idle, f);
    respond(1, 8, 40'h01, all1);
    next_frame(20, idle, f);
    tests++; if (f[19:0] !== 20'h69400) begin fails++; $display("FAIL acmd41_head: got %h want 69400", f[19:0]); end
    k = 0;
    while (SD_CK !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    rst_n = 1'b1;
    #1;
    tests++; if (SD_CK !== 1'b0) begin fails++; $display("FAIL abort_sck: got %b want 0", SD_CK); end
    tests++; if (SD_MOSI !== 1'b1) begin fails++; $display("FAIL abort_mosi: got %b want 1", SD_MOSI); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", init_done); end
    tests++; if (DUT.sd_initial.state !== 4'd0) begin
      fails++; $display("FAIL abort_state: got %0d want 0", DUT.sd_initial.state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    next_frame(48, idle, f);
    tests++; if (idle != 80) begin fails++; $display("FAIL restart_dummy: got %0d want 80", idle); end
    tests++; if (f !== EXP_CMD0) begin fails++; $display("FAIL restart_cmd0: got %h want %h", f, EXP_CMD0); end
  endtask

  task automatic test_no_stall;
    tests++; if (stalls != 0) begin fails++; $display("FAIL sck_stall: got %0d stalls want 0", stalls); end
  endtask

  initial begin
    test_reset();
    test_dummy();
    test_cmd0_timeout();
    test_cmd0_bad();
    test_cmd0_ok();
    test_cmd8();
    test_acmd41_loop();
    test_reset_mid_acmd41();
    test_no_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_ctrl_top.md
SD_CTRL_TOP -- requirements
Module: sd_ctrl_top

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per SD_CK half-period (SD_CK = clk/(2*CLK_DIV), 5 MHz at 20 MHz clk).
REQ-002 Parameter TIMEOUT_BYTES, default 8, response bytes to wait for an R1 start bit before retrying the command.
REQ-003 Parameter DUMMY_CLKS, default 80, SD_CK cycles with MOSI high before the first command.
REQ-004 clk  input  1  single system clock, all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-high reset; the polarity and synchronicity are fixed despite the port name.
REQ-006 SD_CK  output  1  SPI serial clock to the card.
REQ-007 SD_MOSI  output  1  command data to the card, MSB first.
REQ-008 SD_MISO  input  1  response data from the card.
REQ-009 init_done  output  1  high once the card has accepted ACMD41 with R1=0x00; may be left unconnected.

Function
REQ-010 SD_CK toggles only while a transfer phase is active; it idles low otherwise.
REQ-011 SD_MOSI changes on SD_CK falling edges; SD_MISO is sampled on SD_CK rising edges.
REQ-012 The initialisation FSM state is a 4-bit register named state: IDLE, DUMMY, CMD0, R_CMD0, CMD8, R_CMD8, CMD55, R_CMD55, ACMD41, R_ACMD41, DONE.
REQ-013 IDLE goes to DUMMY on the first clk after reset release.
REQ-014 DUMMY drives MOSI=1 for DUMMY_CLKS SD_CK cycles, then goes to CMD0.
REQ-015 Each CMDx state shifts a 48-bit frame MSB first, then goes to its R_ state.
REQ-016 The frames are: CMD0 40_00000000_95, CMD8 48_000001AA_87, CMD55 77_00000000_FF, ACMD41 69_40000000_FF (hex).
REQ-017 In an R_ state, MOSI=1 and SD_MISO is sampled until the first 0 bit; that 0 bit is R1 bit7, and the next 7 bits complete R1.
REQ-018 If no 0 bit arrives within TIMEOUT_BYTES*8 SD_CK cycles, the FSM returns to the same CMD state.
REQ-019 R_CMD0: R1=0x01 goes to CMD8; any other value goes to CMD0.
REQ-020 R_CMD8: after R1, 32 more bits are read; R1=0x01 with last byte 0xAA goes to CMD55, otherwise CMD0.
REQ-021 R_CMD55: any R1 value goes to ACMD41.
REQ-022 R_ACMD41: R1=0x00 goes to DONE; R1=0x01 goes to CMD55; any other value goes to CMD0.
REQ-023 Every command is followed by 8 SD_CK cycles of MOSI=1 before the next state begins.
REQ-024 DONE holds permanently: init_done=1, SD_CK=0, MOSI=1.

Reset
REQ-025 Reset asserted sets state=IDLE, SD_CK=0, SD_MOSI=1, init_done=0, and clears all counters and shift registers.
REQ-026 Reset asserted mid-command aborts the command immediately; after release the sequence restarts from DUMMY.

Structure
REQ-027 The command frames, state encodings, CLK_DIV, TIMEOUT_BYTES and DUMMY_CLKS belong in the shared package sd_pkg.
REQ-028 The top holds one sub-module, sd_initial, instance name sd_initial, containing the FSM with register state, the SPI clock divider and the shifters.
REQ-029 state is reachable hierarchically as DUT.sd_initial.state.

Verification
REQ-030 Release reset and leave MISO=1 -> exactly 80 SD_CK cycles with MOSI=1, then the CMD0 frame appears on MOSI.
REQ-031 Card model answers CMD0 with 0x01 -> the CMD8 frame 48000001AA87 follows after 8 idle SD_CK cycles.
REQ-032 CMD8 answered with 01_000001AA -> CMD55 is sent; answered with 01_00000055 -> CMD0 is re-sent.
REQ-033 ACMD41 answered with 0x01 twice, then 0x00 -> the CMD55/ACMD41 pair is sent 3 times, then state=DONE, init_done=1 and SD_CK is stopped.
REQ-034 No response to CMD0 (MISO stuck at 1) -> CMD0 is retried after 64 SD_CK cycles, and retries repeat indefinitely.
REQ-035 Reset asserted during the ACMD41 frame -> outputs take their reset values at once, and the sequence restarts with DUMMY after release.
